// File: rtl/pipe_alu_n.sv
// pipe_alu_n: four-stage register-to-register ALU pipeline (read, execute,
// writeback, store/retire) with a writable register bank and a result memory.
// Build option: define PIPE_ALU_N_FWD_EN to resolve read-after-write hazards
// by operand forwarding; left undefined, an issue interlock stalls instead.
module pipe_alu_n #(
  parameter  int unsigned DATA_W    = 16,
  parameter  int unsigned REG_N     = 16,
  parameter  int unsigned MEM_DEPTH = 256,
  localparam int unsigned RW        = $clog2(REG_N),
  localparam int unsigned AW        = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RW-1:0]     rs1,
  input  logic [RW-1:0]     rs2,
  input  logic [RW-1:0]     rd,
  input  logic [3:0]        func,
  input  logic [AW-1:0]     addr,
  input  logic              cfg_we,
  input  logic [RW-1:0]     cfg_idx,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [AW-1:0]     mem_raddr,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              z_valid,
  output logic [DATA_W-1:0] z_out,
  output logic [AW-1:0]     z_addr,
  output logic              z_illegal
);

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_MUL    = 4'd2,
    OP_PASS_A = 4'd3,
    OP_PASS_B = 4'd4,
    OP_AND    = 4'd5,
    OP_OR     = 4'd6,
    OP_XOR    = 4'd7,
    OP_NEG    = 4'd8,
    OP_NOT_B  = 4'd9,
    OP_SHR    = 4'd10,
    OP_SHL    = 4'd11
  } op_e;

  logic [DATA_W-1:0] bank [REG_N];
  logic [DATA_W-1:0] mem  [MEM_DEPTH];

  // S1: operands and control captured at issue
  logic              s1_valid;
  logic [DATA_W-1:0] s1_a, s1_b;
  logic [RW-1:0]     s1_rd;
  logic [3:0]        s1_func;
  logic [AW-1:0]     s1_addr;
  // S2: executed result awaiting writeback
  logic              s2_valid;
  logic [DATA_W-1:0] s2_z;
  logic [RW-1:0]     s2_rd;
  logic [AW-1:0]     s2_addr;
  logic              s2_ill;
  // S3: written-back result awaiting store
  logic              s3_valid;
  logic [DATA_W-1:0] s3_z;
  logic [AW-1:0]     s3_addr;
  logic              s3_ill;

  logic [DATA_W-1:0] alu_z;
  logic              alu_ill;
  logic [DATA_W-1:0] op_a, op_b;
  logic              accept;

  // Execute: combinational ALU on the S1 operands
  always_comb begin
    alu_z   = '0;
    alu_ill = 1'b0;
    case (s1_func)
      OP_ADD:    alu_z = s1_a + s1_b;
      OP_SUB:    alu_z = s1_a - s1_b;
      OP_MUL:    alu_z = s1_a * s1_b;
      OP_PASS_A: alu_z = s1_a;
      OP_PASS_B: alu_z = s1_b;
      OP_AND:    alu_z = s1_a & s1_b;
      OP_OR:     alu_z = s1_a | s1_b;
      OP_XOR:    alu_z = s1_a ^ s1_b;
      OP_NEG:    alu_z = -s1_a;
      OP_NOT_B:  alu_z = ~s1_b;
      OP_SHR:    alu_z = s1_a >> 1;
      OP_SHL:    alu_z = s1_a << 1;
      default:   alu_ill = 1'b1;
    endcase
  end

`ifdef PIPE_ALU_N_FWD_EN
  // Operand select: S1 (youngest) result overrides S2, which overrides the bank
  always_comb begin
    op_a = bank[rs1];
    op_b = bank[rs2];
    if (s2_valid && (s2_rd == rs1)) op_a = s2_z;
    if (s2_valid && (s2_rd == rs2)) op_b = s2_z;
    if (s1_valid && (s1_rd == rs1)) op_a = alu_z;
    if (s1_valid && (s1_rd == rs2)) op_b = alu_z;
  end

  assign in_ready = rst_n;
`else
  logic hazard;

  assign op_a   = bank[rs1];
  assign op_b   = bank[rs2];
  // S1 and S2 results are not yet in the bank; hold issue until they are
  assign hazard = (s1_valid && ((s1_rd == rs1) || (s1_rd == rs2))) ||
                  (s2_valid && ((s2_rd == rs1) || (s2_rd == rs2)));
  assign in_ready = rst_n & ~hazard;
`endif

  assign accept = in_valid & in_ready;

  // Pipeline stage registers and retire outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_rd     <= '0;
      s1_func   <= '0;
      s1_addr   <= '0;
      s2_valid  <= 1'b0;
      s2_z      <= '0;
      s2_rd     <= '0;
      s2_addr   <= '0;
      s2_ill    <= 1'b0;
      s3_valid  <= 1'b0;
      s3_z      <= '0;
      s3_addr   <= '0;
      s3_ill    <= 1'b0;
      z_valid   <= 1'b0;
      z_out     <= '0;
      z_addr    <= '0;
      z_illegal <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a    <= op_a;
        s1_b    <= op_b;
        s1_rd   <= rd;
        s1_func <= func;
        s1_addr <= addr;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_z    <= alu_z;
        s2_ill  <= alu_ill;
        s2_rd   <= s1_rd;
        s2_addr <= s1_addr;
      end
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_z    <= s2_z;
        s3_ill  <= s2_ill;
        s3_addr <= s2_addr;
      end
      z_valid <= s3_valid;
      if (s3_valid) begin
        z_out     <= s3_z;
        z_addr    <= s3_addr;
        z_illegal <= s3_ill;
      end
    end
  end

  // Register bank: the pipeline writeback is ordered last so it wins a same-index collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_N; i++) bank[i] <= '0;
    end else begin
      if (cfg_we)   bank[cfg_idx] <= cfg_data;
      if (s2_valid) bank[s2_rd]   <= s2_z;
    end
  end

  // Result memory store (contents are not reset)
  always_ff @(posedge clk) begin
    if (s3_valid) mem[s3_addr] <= s3_z;
  end

  // Registered memory read port; a same-edge write returns the old word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_rdata <= '0;
    else        mem_rdata <= mem[mem_raddr];
  end

endmodule

// File: doc/pipe_alu_n.md
# pipe_alu_n

Parametrised four-stage register-to-register ALU pipeline with a writable register bank and a result store memory. It is the next generation of the team's two-phase 16-bit four-stage pipeline: a single clock, a valid/ready issue handshake, generic data width and bank depth, and defined results for every function code. It also handles read-after-write hazards, either by operand forwarding or by an issue interlock. It sits between the instruction issue logic and the scratch result memory.

## Interface
- `DATA_W`, default 16: operand, result and memory word width (≥4).
- `REG_N`, default 16: register bank entries, power of 2; `RW = $clog2(REG_N)`.
- `MEM_DEPTH`, default 256: result memory words, power of 2; `AW = $clog2(MEM_DEPTH)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: issue request.
- `in_ready` out 1: issue accepted when `in_valid & in_ready`.
- `rs1`, `rs2`, `rd` in RW: source and destination register indices.
- `func` in 4: operation code.
- `addr` in AW: result memory write address.
- `cfg_we` in 1: direct register bank write enable.
- `cfg_idx` in RW, `cfg_data` in DATA_W: direct write index and data.
- `mem_raddr` in AW: memory read address.
- `mem_rdata` out DATA_W: registered memory read data.
- `z_valid` out 1: one-cycle strobe, instruction retired.
- `z_out` out DATA_W: retired result.
- `z_addr` out AW: address the retired result was stored to.
- `z_illegal` out 1: retired instruction had an undefined `func`.

## Operation
Pipeline stages, each with its own valid bit:
- **S1 (issue/read):** on accept, capture operands A = reg[`rs1`] and B = reg[`rs2`] (after bypass), plus `rd`, `func` and `addr`.
- **S2 (execute):** capture Z = f(A, B).
- **S3 (writeback):** on the edge moving S2→S3, write reg[`rd`] ← Z.
- **S4 (store/retire):** on the edge moving S3→S4, write mem[`addr`] ← Z and drive `z_*`.

`func` encoding:
- 0: A+B
- 1: A−B
- 2: A*B, low DATA_W bits
- 3: A
- 4: B
- 5: A&B
- 6: A|B
- 7: A^B
- 8: −A, two's complement
- 9: ~B
- 10: A>>1, logical
- 11: A<<1
- 12–15: Z=0 and `z_illegal`=1 at retire. reg[`rd`] and the memory are still written with 0.

Wrap-around: all arithmetic is modulo 2^DATA_W, and no flags are produced.

Register bank:
- Resets to all zero. The memory is not reset.
- If a `cfg_we` write and a pipeline writeback target the same index on the same edge, the pipeline writeback wins.
- Register reads in S1 see a `cfg_we` write only from the cycle after that write.

Memory read port:
- `mem_rdata` ← mem[`mem_raddr`] one cycle later.
- If the read address is being written on the same edge, `mem_rdata` returns the old data.

No output backpressure. Once accepted, an instruction always retires exactly 4 edges later.

Reset, asserted at any time:
- All valid bits clear, and in-flight instructions are dropped with no further register or memory writes.
- Output reset values: `z_valid`=0, `z_out`=0, `z_addr`=0, `z_illegal`=0, `mem_rdata`=0.
- `in_ready` is 0 while `rst_n`=0 and 1 in the first cycle after release.

## Timing
- Instruction accepted at edge k:
  - S1 loaded at edge k.
  - S2 loaded at k+1.
  - Register bank written at k+2.
  - Memory written, with `z_valid`=1, in the cycle after k+3.
- Throughput: one instruction per cycle when there are no interlock stalls.
- Hazard sources, for an instruction waiting at the input:
  - the valid S1 instruction, whose result is the live ALU output;
  - the valid S2 instruction, whose writeback happens on the current edge.
- Sources with `rd` == `rs1`/`rs2` are checked per operand. The youngest source (S1) has priority over S2.
- S3 and older results are already in the bank and need no handling.

## Configuration
- `PIPE_ALU_N_FWD_EN` defined:
  - matching operands are bypassed from the S1 ALU output or the S2 result;
  - `in_ready` is 1 whenever out of reset;
  - a back-to-back dependent instruction sees the new value with zero bubbles.
- `PIPE_ALU_N_FWD_EN` undefined, interlock:
  - `in_ready`=0 while any hazard source matches `rs1` or `rs2`;
  - S1 inserts a bubble with its valid bit at 0;
  - an immediately dependent instruction stalls for 2 cycles.
- Results are identical in both builds; only the timing differs.

## Test plan
- Reset, then `cfg_we` loads r1=5 and r2=3. Issue func 0, rd=3, addr=0x10 → `z_valid` exactly 4 cycles after accept, `z_out`=8, `z_addr`=0x10. Reading mem[0x10] then gives 8.
- All 16 funcs with A=0x8001, B=0x0003, DATA_W=16 → results:
  - 0x8004 (add), 0x7FFE (sub), 0x8003 (mul, low bits), 0x8001 (A), 0x0003 (B);
  - 0x0001 (and), 0x8003 (or), 0x8002 (xor), 0x7FFF (neg), 0xFFFC (not);
  - 0x4000 (>>1), 0x0002 (<<1);
  - funcs 12–15: 0 with `z_illegal`=1.
- Dependent chain r3=r1+r2, then r4=r3+r3, then r5=r4−r1, with r1=5 and r2=3:
  - results 8, 16, 11 in every build;
  - with FWD_EN, 3 consecutive `z_valid` strobes;
  - without FWD_EN, `in_ready` is low for 2 cycles before each dependent issue.
- Same-edge collision: `cfg_we` to r3=0xAAAA on the writeback edge of r3=8 → r3 reads back as 8.
- `rst_n` pulsed low with 3 instructions in flight → no `z_valid` strobes, bank all 0, target memory words unchanged.
- Random stream of 1000 instructions against a reference model, with random `cfg_we` writes and `mem_raddr` reads → results, bank contents and memory contents match in both builds.
